// File: rtl/or_seq_pkg.sv
// Shared definitions for the sequenced OR-reduction controller:
// FSM state encoding and the index-width helper.
package or_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that addresses bit positions 0..n-1 (never below 1).
  function automatic int calc_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/or_chain_sequencer_or_step.sv
// Single 2-input OR cell, time-multiplexed across all bit positions by
// the sequencer.
module or_step (
  input  logic acc_in,
  input  logic bit_in,
  output logic acc_out
);

  assign acc_out = acc_in | bit_in;

endmodule

// File: rtl/or_chain_sequencer.sv
// Sequenced OR-reduction controller: accepts an N-bit operand over a
// valid/ready handshake and walks it through one shared OR cell, one bit
// per clock, producing the running prefix ORs and the final reduction.
// Optional build macro OR_SEQ_EARLY_EXIT_EN: finish as soon as the running
// OR becomes 1, filling the remaining prefix bits with 1.
module or_chain_sequencer
  import or_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_result,
  output logic [N-1:0] out_prefix,
  output logic         busy
);

  localparam int IDX_W = calc_idx_w(N);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'((N > 1) ? 1 : 0);

`ifdef OR_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t           r_state;
  logic [N-1:0]     r_data;
  logic [N-1:0]     r_prefix;
  logic [IDX_W-1:0] r_idx;
  logic             r_acc;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_acc_in;
  logic             w_bit_in;
  logic             w_acc_next;
  logic             w_run_exit;
  logic [N-1:0]     w_hi_mask;

  // Steer the shared OR cell: operand bit 0 with a cleared accumulator on
  // the accept edge, otherwise the accumulator with the current indexed bit.
  always_comb begin
    w_acc_in = 1'b0;
    w_bit_in = in_data[0];
    if (r_state == ST_RUN) begin
      w_acc_in = r_acc;
      w_bit_in = r_data[r_idx];
    end
  end

  // Mask of unprocessed positions (current index and above) for early exit,
  // plus the decision to leave RUN on this edge.
  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_hi_mask[i] = (i >= int'(r_idx));
    end
    w_run_exit = (r_idx == LAST_IDX) || (EARLY_EXIT && w_acc_next);
  end

  or_step u_or_step (
    .acc_in  (w_acc_in),
    .bit_in  (w_bit_in),
    .acc_out (w_acc_next)
  );

  // Control FSM, index counter and datapath registers with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_prefix    <= '0;
      r_idx       <= '0;
      r_acc       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_data      <= in_data;
            r_acc       <= w_acc_next;
            r_prefix    <= '0;
            r_prefix[0] <= w_acc_next;
            if (EARLY_EXIT && w_acc_next) r_prefix <= '1;
            r_idx       <= FIRST_IDX;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            if ((N == 1) || (EARLY_EXIT && w_acc_next)) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_acc           <= w_acc_next;
          r_prefix[r_idx] <= w_acc_next;
          if (EARLY_EXIT && w_acc_next) r_prefix <= r_prefix | w_hi_mask;
          if (w_run_exit) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_acc;
  assign out_prefix = r_prefix;
  assign busy       = r_busy;

endmodule

// File: doc/or_chain_sequencer.md
Name: or_chain_sequencer

Overview:
- Sequenced OR-reduction controller. Accepts an N-bit operand over a valid/ready handshake and walks it through a single 2-input OR step, one bit per clock.
- Produces the running prefix ORs: prefix[i] = in_data[0] | ... | in_data[i]. The final reduction equals prefix[N-1].
- Sits between an operand producer and a result consumer. Replaces a purely combinational OR chain wherever one shared OR cell must be time-multiplexed across bit positions.

Parameters:
- N, 4, operand width in bits; legal range 1..32.
- IDX_W, $clog2(N) (minimum 1), bit-index counter width; derived, never overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block can accept an operand.
- in_data  input  N  operand; sampled only on the accept edge.
- out_valid  output  1  result and prefix are valid.
- out_ready  input  1  consumer takes the result.
- out_result  output  1  OR of all N operand bits.
- out_prefix  output  N  prefix ORs, bit i = OR of operand bits 0..i.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports named clk and rst.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_result=0, out_prefix=0, busy=0.
  - Internal accumulator, index and operand register all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept edge = in_valid & in_ready. On it: capture in_data; acc<=in_data[0]; prefix[0]<=in_data[0]; prefix[N-1:1]<=0; idx<=1.
  - Next state is RUN, or DONE if N==1.
- RUN, each edge:
  - acc<=acc|data[idx]; prefix[idx]<=acc|data[idx]; idx<=idx+1.
  - When idx==N-1, go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; out_result=acc.
  - out_prefix and out_result stay stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE next edge; out_valid drops.
  - No same-cycle re-accept: in_ready stays 0 in DONE.
- Latency: out_valid rises N-1 edges after the accept edge (N=1: immediately after the accept edge).
- Throughput: one operand per N+1 cycles, minimum.
- in_valid while not ready: ignored. Producer must hold the operand.
- in_data changes after accept: no effect (captured copy is used).
- rst asserted mid-RUN or mid-DONE: immediate return to reset values. The in-flight operand is discarded and no out_valid is produced.
- Index never exceeds N-1. No wrap-around is possible.

Optional Feature:
- Macro: OR_SEQ_EARLY_EXIT_EN.
- Defined:
  - If acc|data[idx] is 1 on an edge (including the accept edge), go to DONE immediately.
  - All unprocessed prefix bits at positions >= that bit are set to 1.
  - Result and prefix are identical to full-walk mode; latency is shorter.
- Undefined: always walks all N bits; latency is fixed at N-1.

Decomposition:
- Package or_seq_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Helper function computing IDX_W from N.
- Sub-module or_step: combinational 2-input OR (acc_in, bit_in -> acc_out), instantiated once as the shared datapath cell.
- FSM, counter and registers stay in the top module.

Test Plan:
- N=4, in_data=4'b0000, out_ready=1:
  - Accepted on edge t0.
  - out_valid high after edge t3.
  - out_result=0, out_prefix=4'b0000.
- N=4, in_data=4'b0100:
  - out_prefix=4'b1100, out_result=1.
  - Without OR_SEQ_EARLY_EXIT_EN: out_valid after t3.
  - With it: out_valid after t2.
- N=4, in_data=4'b0001, OR_SEQ_EARLY_EXIT_EN defined: DONE directly after the accept edge; out_prefix=4'b1111, out_result=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1; out_prefix/out_result stable; in_ready=0; a new in_valid is ignored.
  - Release out_ready: IDLE next edge, in_ready=1.
- Reset mid-RUN: assert rst asynchronously after edge t1 of a 4'b1010 operation.
  - All outputs immediately at reset values.
  - After release, a fresh 4'b0010 operation gives out_prefix=4'b1110.
- N=1 build, in_data=1'b1: out_valid right after the accept edge; out_result=1, out_prefix=1'b1.
